// File: rtl/hypot_pkg.sv
// Shared types and constants for the hypotenuse scheduler (hypot_sched and hypot_rr_arb).
package hypot_pkg;

  localparam int W_DEF = 8;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SQX,
    SQY,
    ROOT,
    ROUND,
    DONE
  } state_t;

  // isqrt(2*(2^w-1)^2) always fits in w+1 bits
  function automatic int res_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/hypot_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the losing side on accept.
module hypot_rr_arb
  import hypot_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant,
  output logic grant_valid
);

  logic ptr;

  // A lone requester always wins; a tie goes to the pointer side
  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = ptr;
    if (valid0 && !valid1) begin
      grant = ID_REQ0;
    end else if (!valid0 && valid1) begin
      grant = ID_REQ1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_REQ0;
    end else if (accept) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/hypot_sched.sv
// Multi-cycle isqrt(x*x + y*y) scheduler sharing one squarer between two requesters.
// Optional round-to-nearest stage enabled by defining HYPOT_SCHED_ROUND_EN.
module hypot_sched
  import hypot_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [W-1:0]            req0_x,
  input  logic [W-1:0]            req0_y,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [W-1:0]            req1_x,
  input  logic [W-1:0]            req1_y,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [res_width(W)-1:0] res_data,
  output logic                    res_id,
  output logic                    busy
);

  localparam int RW = res_width(W);
  localparam int PW = 2 * RW;
  localparam int AW = 2 * W + 1;
  localparam int BW = $clog2(RW);

  state_t          state;
  logic [W-1:0]    x_r;
  logic [W-1:0]    y_r;
  logic            id_r;
  logic [AW-1:0]   acc;
  logic [RW-1:0]   root_r;
  logic [BW-1:0]   bit_idx;

  logic            grant;
  logic            grant_valid;
  logic            accept;
  logic [RW-1:0]   mul_op;
  logic [PW-1:0]   prod;
  logic [RW-1:0]   cand;
  logic            fits;
  logic [RW-1:0]   root_next;

`ifdef HYPOT_SCHED_ROUND_EN
  logic [PW-1:0]   sq_r;
  logic [PW-1:0]   rem;
  logic [RW-1:0]   root_rnd;
`endif

  hypot_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .accept      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Readys are also masked by rst_n so every output reads zero while reset is held
  assign req0_ready = rst_n & ena & (state == IDLE) & grant_valid & (grant == ID_REQ0);
  assign req1_ready = rst_n & ena & (state == IDLE) & grant_valid & (grant == ID_REQ1);
  assign accept     = req0_ready | req1_ready;

  // Single shared squarer: operand chosen by the current state
  always_comb begin
    mul_op = '0;
    case (state)
      SQX:     mul_op = {1'b0, x_r};
      SQY:     mul_op = {1'b0, y_r};
      ROOT:    mul_op = cand;
      default: mul_op = '0;
    endcase
  end

  assign prod      = mul_op * mul_op;
  assign cand      = root_r | (RW'(1) << bit_idx);
  assign fits      = (prod <= PW'(acc));
  assign root_next = fits ? cand : root_r;

`ifdef HYPOT_SCHED_ROUND_EN
  // acc - r*r > r selects the nearer integer; an exact tie cannot occur
  assign rem      = PW'(acc) - sq_r;
  assign root_rnd = (rem > PW'(root_r)) ? (root_r + RW'(1)) : root_r;
`endif

  // Main FSM: everything is frozen while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      id_r      <= ID_REQ0;
      acc       <= '0;
      root_r    <= '0;
      bit_idx   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= ID_REQ0;
      busy      <= 1'b0;
`ifdef HYPOT_SCHED_ROUND_EN
      sq_r      <= '0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_r    <= (grant == ID_REQ1) ? req1_x : req0_x;
            y_r    <= (grant == ID_REQ1) ? req1_y : req0_y;
            id_r   <= grant;
            root_r <= '0;
            busy   <= 1'b1;
`ifdef HYPOT_SCHED_ROUND_EN
            sq_r   <= '0;
`endif
            state  <= SQX;
          end
        end
        SQX: begin
          acc   <= prod[AW-1:0];
          state <= SQY;
        end
        SQY: begin
          acc     <= acc + prod[AW-1:0];
          bit_idx <= BW'(W);
          state   <= ROOT;
        end
        ROOT: begin
          root_r <= root_next;
`ifdef HYPOT_SCHED_ROUND_EN
          if (fits) begin
            sq_r <= prod;
          end
`endif
          if (bit_idx == '0) begin
`ifdef HYPOT_SCHED_ROUND_EN
            state     <= ROUND;
`else
            res_data  <= root_next;
            res_id    <= id_r;
            res_valid <= 1'b1;
            state     <= DONE;
`endif
          end else begin
            bit_idx <= bit_idx - BW'(1);
          end
        end
`ifdef HYPOT_SCHED_ROUND_EN
        ROUND: begin
          res_data  <= root_rnd;
          res_id    <= id_r;
          res_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
